// File: rtl/constants_pkg.sv
// ============================================================================
// Module      : constants_pkg
// Description : Architectural widths and fetch-stage default constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package constants_pkg;

    localparam int          ARCH_LEN         = 32;
    localparam int          INST_LEN         = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/structure_pkg.sv
// ============================================================================
// Module      : structure_pkg
// Description : Shared types for the fetch stage and its decode-side consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package structure_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic                                valid;
        logic [constants_pkg::INST_LEN-1:0]  inst;
    } inst_fetched_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// Module      : fetch_skid_buffer
// Description : One-entry {inst, pc} holding register used while decode stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buffer
    import constants_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_drain,
    input  logic                i_flush,
    input  logic [INST_LEN-1:0] i_inst,
    input  logic [ARCH_LEN-1:0] i_pc,
    output logic                o_full,
    output logic [INST_LEN-1:0] o_inst,
    output logic [ARCH_LEN-1:0] o_pc
);

    logic                r_full;
    logic [INST_LEN-1:0] r_inst;
    logic [ARCH_LEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_inst <= '0;
            r_pc   <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_inst = r_inst;
    assign o_pc   = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Single-outstanding instruction fetch front end feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import constants_pkg::*;
    import structure_pkg::*;
#(
    parameter logic [ARCH_LEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INST_LEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_to_use_hazard,
    input  logic                branch_taken,
    input  logic [ARCH_LEN-1:0] branch_target,
    output logic                imem_req_valid,
    output logic [ARCH_LEN-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INST_LEN-1:0] imem_rsp_data,
    output inst_fetched_t       inst_fetched_out,
    output logic [ARCH_LEN-1:0] pc_out
);

    fetch_state_t        r_state, w_state_next;
    logic [ARCH_LEN-1:0] r_pc, w_pc_next, w_pc_plus4;
    inst_fetched_t       r_out, w_out_next;
    logic [ARCH_LEN-1:0] r_pc_out, w_pc_out_next;

    logic                w_skid_load, w_skid_drain, w_skid_flush, w_skid_full;
    logic [INST_LEN-1:0] w_skid_inst;
    logic [ARCH_LEN-1:0] w_skid_pc;

    // Low target bits are architecturally ignored.
    logic w_unused_target_lsbs;
    assign w_unused_target_lsbs = &{1'b0, branch_target[1:0]};

    // A redirecting cycle must not launch a request to the stale PC.
    assign imem_req_valid = (r_state == REQ) && !rst && !branch_taken;
    assign imem_req_addr  = r_pc;
    assign w_pc_plus4     = r_pc + ARCH_LEN'(4);

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_out_next    = r_out;
        w_pc_out_next = r_pc_out;
        w_skid_load   = 1'b0;
        w_skid_drain  = 1'b0;
        w_skid_flush  = 1'b0;

        if (branch_taken) begin
            w_pc_next        = {branch_target[ARCH_LEN-1:2], 2'b00};
            w_skid_flush     = 1'b1;
            w_out_next.valid = 1'b0;
            w_out_next.inst  = NOP_INST;
            // Still owed a response for the squashed request unless it is here now.
            if ((r_state == WAIT || r_state == DRAIN) && !imem_rsp_valid) begin
                w_state_next = DRAIN;
            end else begin
                w_state_next = REQ;
            end
        end else begin
            case (r_state)
                REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (load_to_use_hazard) begin
                            w_skid_load  = 1'b1;
                            w_state_next = HOLD;
                        end else begin
                            w_pc_next    = w_pc_plus4;
                            w_state_next = REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!load_to_use_hazard) begin
                        w_skid_drain = 1'b1;
                        w_pc_next    = w_pc_plus4;
                        w_state_next = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        w_state_next = REQ;
                    end
                end
                default: w_state_next = REQ;
            endcase

            if (!load_to_use_hazard) begin
                if (r_state == WAIT && imem_rsp_valid) begin
                    w_out_next.valid = 1'b1;
                    w_out_next.inst  = imem_rsp_data;
                    w_pc_out_next    = w_pc_plus4;
                end else if (r_state == HOLD && w_skid_full) begin
                    w_out_next.valid = 1'b1;
                    w_out_next.inst  = w_skid_inst;
                    w_pc_out_next    = w_skid_pc + ARCH_LEN'(4);
                end else begin
                    w_out_next.valid = 1'b0;
                    w_out_next.inst  = NOP_INST;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_out      <= '{valid: 1'b0, inst: NOP_INST};
            r_pc_out   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_out      <= w_out_next;
            r_pc_out   <= w_pc_out_next;
        end
    end

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_flush (w_skid_flush),
        .i_inst  (imem_rsp_data),
        .i_pc    (r_pc),
        .o_full  (w_skid_full),
        .o_inst  (w_skid_inst),
        .o_pc    (w_skid_pc)
    );

    assign inst_fetched_out = r_out;
    assign pc_out           = r_pc_out;

endmodule

`default_nettype wire
